data_ram: RTL and testbench
===========================

// Module: data_ram
// PURPOSE
//  - Single-port synchronous data RAM for the CPU data path (load/store unit).
//    One request per clock: read or write, selected by read_not_write and gated by cs.
//  - Write port is 24 bits wide (the datapath width). The array and the read port are 16 bits wide.
// PARAMETERS
//  ADDR_W   11           address width; DEPTH = 2**ADDR_W = 2048 words
//  WDATA_W  24           write_data width
//  RDATA_W  16           read_data width; also the stored word width (RDATA_W <= WDATA_W)
// PORTS
//  clk            in   1        single clock; all state changes on rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  address        in   ADDR_W   word address, 0..DEPTH-1
//  write_data     in   WDATA_W  store data; only bits [RDATA_W-1:0] are kept
//  read_data      out  RDATA_W  registered read data
//  read_not_write in   1        1 = read, 0 = write (valid only while cs=1)
//  cs             in   1        chip select, active-high
//  ready          out  1        1 = array accepts requests (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: rst_n=0 immediately forces read_data=0 and ready=0, asynchronously.
//    Without DATA_RAM_CLEAR_EN, ready returns to 1 on the first rising edge after rst_n rises.
//  - Write: on a rising edge with cs=1, read_not_write=0 and ready=1:
//    mem[address] <= write_data[RDATA_W-1:0]. Bits [WDATA_W-1:RDATA_W] are discarded.
//    read_data holds its value.
//  - Read: on a rising edge with cs=1, read_not_write=1 and ready=1:
//    read_data <= mem[address]. Latency is 1 cycle; the value is visible after that edge.
//  - Idle: with cs=0 there is no access and read_data holds.
//  - Requests made while ready=0 are ignored entirely: no write, and read_data holds.
//  - Reset mid-operation: the in-flight edge is lost. Array contents are preserved unless
//    DATA_RAM_CLEAR_EN is defined.
//  - Address coverage: the full 0..DEPTH-1 range is valid; there is no wrap logic and no
//    out-of-range case.
//  - An unwritten location reads as X in simulation, unless DATA_RAM_CLEAR_EN is defined.
//  - Single port: read and write can never occur in the same cycle.
// CONFIGURATION
//  - DATA_RAM_CLEAR_EN defined: after rst_n rises, a 2-state FSM runs.
//    - CLEAR: writes 0 to address 0..DEPTH-1, one word per clock, using an internal ADDR_W
//      counter; ready=0 throughout.
//    - RUN: entered after word DEPTH-1 is written; ready=1.
//    - Total clear time is DEPTH cycles.
//    - Reset during CLEAR restarts the sweep at address 0.
//  - DATA_RAM_CLEAR_EN not defined:
//    - No FSM and no counter.
//    - ready is a single flop: 0 during reset, 1 from the first edge after reset.
//    - Contents are not initialised.
// STRUCTURE
//  - Shared package data_ram_pkg holds the defaults ADDR_W, WDATA_W and RDATA_W, and the
//    FSM enum typedef {CLEAR, RUN}.
//  - Optional sub-module data_ram_array: a bare clocked 2D register array with a write
//    enable, no reset. The top-level module holds the request decode, the read_data
//    register, and the FSM/ready logic.
// TESTING
//  1 Reset: rst_n=0 -> read_data=0, ready=0. Release, then wait for ready=1:
//    1 edge without the macro, DEPTH+1 edges with it.
//  2 Write then read back: write 63 to addr 16, write 10 to addr 24, read addr 16
//    -> read_data=63 one edge later; read addr 24 -> 10.
//  3 Truncation: write 24'hABCDEF to addr 5, read addr 5 -> 16'hCDEF.
//  4 Chip select: with cs=0, rnw=0 and data 99 at addr 16 -> a later read of addr 16
//    still returns 63. read_data holds through cs=0 cycles and through write cycles.
//  5 Boundaries: write 1 to addr 0 and 16'hFFFF to addr 2047, read both back exact;
//    addr 1 is unaffected.
//  6 Clear (macro defined): after test 2, pulse rst_n -> no request is accepted while
//    ready=0; once ready=1, a read of addr 16 returns 0.
//    Without the macro, addr 16 still reads 63.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared defaults and state type for the data RAM.
// The type is used only when the build defines DATA_RAM_CLEAR_EN.
package data_ram_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned WDATA_W = 24;
    localparam int unsigned RDATA_W = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/data_ram_array.sv
// Bare storage array: clocked write, combinational read, no reset.
module data_ram_array #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata_c = mem_q[addr];

endmodule

// File: rtl/data_ram.sv
// Single-port data RAM: 24-bit store port, 16-bit array and registered read port.
// Optional DATA_RAM_CLEAR_EN adds a post-reset zero sweep before ready asserts.
module data_ram #(
    parameter int unsigned ADDR_W  = data_ram_pkg::ADDR_W,
    parameter int unsigned WDATA_W = data_ram_pkg::WDATA_W,
    parameter int unsigned RDATA_W = data_ram_pkg::RDATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  address,
    input  logic [WDATA_W-1:0] write_data,
    output logic [RDATA_W-1:0] read_data,
    input  logic               read_not_write,
    input  logic               cs,
    output logic               ready
);

    import data_ram_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic               ready_q, ready_d;
    logic [RDATA_W-1:0] read_data_q, read_data_d;
    logic               req_c;
    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    logic [RDATA_W-1:0] mem_wdata_c;
    logic [RDATA_W-1:0] mem_rdata_c;

    // Upper store bits are architecturally dropped.
    if (WDATA_W > RDATA_W) begin : g_trunc
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^write_data[WDATA_W-1:RDATA_W];
    end

    assign req_c = cs && ready_q;

`ifdef DATA_RAM_CLEAR_EN
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // Sweep every word to zero, then hand the array to the requester.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        ready_d     = (state_q == RUN);
        mem_we_c    = req_c && !read_not_write;
        mem_addr_c  = address;
        mem_wdata_c = write_data[RDATA_W-1:0];
        if (state_q == CLEAR) begin
            clr_addr_d  = clr_addr_q + ADDR_W'(1);
            mem_we_c    = 1'b1;
            mem_addr_c  = clr_addr_q;
            mem_wdata_c = '0;
            if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end
`else
    always_comb begin
        ready_d     = 1'b1;
        mem_we_c    = req_c && !read_not_write;
        mem_addr_c  = address;
        mem_wdata_c = write_data[RDATA_W-1:0];
    end
`endif

    always_comb begin
        read_data_d = read_data_q;
        if (req_c && read_not_write) begin
            read_data_d = mem_rdata_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            ready_q     <= ready_d;
            read_data_q <= read_data_d;
        end
    end

    data_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (RDATA_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we_c),
        .addr    (mem_addr_c),
        .wdata   (mem_wdata_c),
        .rdata_c (mem_rdata_c)
    );

    assign read_data = read_data_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed cases plus randomized traffic
// against an array model. Honours DATA_RAM_CLEAR_EN like the design.
module tb_data_ram;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned WDATA_W = 24;
    localparam int unsigned RDATA_W = 16;
    localparam int unsigned DEPTH   = 1 << ADDR_W;
`ifdef DATA_RAM_CLEAR_EN
    localparam int unsigned READY_EDGES = DEPTH + 1;
`else
    localparam int unsigned READY_EDGES = 1;
`endif

    logic               clk;
    logic               rst_n;
    logic [ADDR_W-1:0]  address;
    logic [WDATA_W-1:0] write_data;
    logic [RDATA_W-1:0] read_data;
    logic               read_not_write;
    logic               cs;
    logic               ready;

    data_ram u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data),
        .read_not_write (read_not_write),
        .cs             (cs),
        .ready          (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [RDATA_W-1:0] model   [DEPTH];
    bit                 written [DEPTH];
    logic [RDATA_W-1:0] exp_rd;
    logic               exp_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clocked request; the model applies it only if the array was ready.
    task automatic access(input string tag, input logic c, input logic rnw,
                          input int unsigned a, input logic [WDATA_W-1:0] d);
        @(negedge clk);
        cs             = c;
        read_not_write = rnw;
        address        = ADDR_W'(a);
        write_data     = d;
        @(posedge clk);
        if (c && exp_ready) begin
            if (rnw) exp_rd = model[a];
            else begin
                model[a]   = d[RDATA_W-1:0];
                written[a] = 1'b1;
            end
        end
        #1;
        check({tag, ".rd"}, 32'(read_data), 32'(exp_rd));
        check({tag, ".rdy"}, 32'(ready), 32'(exp_ready));
    endtask

    // Assert reset mid-cycle, check async clear, release, then count edges to ready.
    // A write of 77 to addr 16 is held on the bus the whole time and must be ignored.
    task automatic pulse_reset(input string tag);
        int unsigned edges;
        @(negedge clk);
        cs = 1'b1; read_not_write = 1'b0; address = ADDR_W'(16); write_data = 24'd77;
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".rst_rd"}, 32'(read_data), 32'h0);
        check({tag, ".rst_rdy"}, 32'(ready), 32'h0);
        exp_rd    = '0;
        exp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        while (edges < DEPTH + 8) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready === 1'b1) break;
        end
        cs = 1'b0;
        check({tag, ".ready_edges"}, 32'(edges), 32'(READY_EDGES));
        check({tag, ".hold_rd"}, 32'(read_data), 32'h0);
        exp_ready = 1'b1;
`ifdef DATA_RAM_CLEAR_EN
        for (int i = 0; i < int'(DEPTH); i++) begin
            model[i]   = '0;
            written[i] = 1'b1;
        end
`endif
    endtask

    int unsigned pool [8];

    initial begin
        rst_n = 1'b1; cs = 1'b0; read_not_write = 1'b1; address = '0; write_data = '0;
        exp_rd = '0; exp_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) written[i] = 1'b0;

        // 1: reset and ready latency
        pulse_reset("t1");

        // 2: write then read back
        access("t2.w16", 1'b1, 1'b0, 16, 24'd63);
        access("t2.w24", 1'b1, 1'b0, 24, 24'd10);
        access("t2.r16", 1'b1, 1'b1, 16, 24'd0);
        check("t2.val16", 32'(read_data), 32'd63);
        access("t2.r24", 1'b1, 1'b1, 24, 24'd0);
        check("t2.val24", 32'(read_data), 32'd10);

        // 3: upper store bits dropped
        access("t3.w5", 1'b1, 1'b0, 5, 24'hABCDEF);
        access("t3.r5", 1'b1, 1'b1, 5, 24'd0);
        check("t3.trunc", 32'(read_data), 32'h0000CDEF);

        // 4: chip select gates writes; read_data holds through idle and writes
        access("t4.nocs", 1'b0, 1'b0, 16, 24'd99);
        access("t4.nocs_rd", 1'b0, 1'b1, 24, 24'd0);
        access("t4.w30", 1'b1, 1'b0, 30, 24'd7);
        check("t4.hold", 32'(read_data), 32'hCDEF);
        access("t4.r16", 1'b1, 1'b1, 16, 24'd0);
        check("t4.val16", 32'(read_data), 32'd63);

        // 5: address boundaries
        access("t5.w1", 1'b1, 1'b0, 1, 24'h000123);
        access("t5.w0", 1'b1, 1'b0, 0, 24'd1);
        access("t5.wtop", 1'b1, 1'b0, 2047, 24'h00FFFF);
        access("t5.r0", 1'b1, 1'b1, 0, 24'd0);
        check("t5.val0", 32'(read_data), 32'd1);
        access("t5.rtop", 1'b1, 1'b1, 2047, 24'd0);
        check("t5.valtop", 32'(read_data), 32'hFFFF);
        access("t5.r1", 1'b1, 1'b1, 1, 24'd0);
        check("t5.val1", 32'(read_data), 32'h0123);

        // Randomized traffic over a small address pool that includes the ends
        pool[0] = 0; pool[1] = 2047; pool[2] = 16; pool[3] = 24;
        for (int i = 4; i < 8; i++) pool[i] = $urandom_range(0, DEPTH - 1);
        for (int i = 0; i < 300; i++) begin
            int unsigned a;
            logic c, rnw;
            a   = pool[$urandom_range(0, 7)];
            c   = ($urandom_range(0, 3) != 0);
            rnw = $urandom_range(0, 1) == 1;
            if (rnw && !written[a]) rnw = 1'b0;
            access("rnd", c, rnw, a, WDATA_W'($urandom));
        end

        // 6: reset pulse; contents survive unless the clear sweep is built in
        access("t6.w16", 1'b1, 1'b0, 16, 24'd63);
        pulse_reset("t6");
        access("t6.r16", 1'b1, 1'b1, 16, 24'd0);
`ifdef DATA_RAM_CLEAR_EN
        check("t6.val16", 32'(read_data), 32'd0);
`else
        check("t6.val16", 32'(read_data), 32'd63);
`endif

        @(negedge clk);
        cs = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
